div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider in the EX stage, the requesting side of the pipeline stall controller. While a DIV/DIVU executes it drives `stallreq_for_ex`, which the controller turns into a `StallBus` pattern freezing PC, IF, ID and EX. When the result is ready it drops the request, so the instruction leaves EX with `{remainder, quotient}` for HI/LO writeback.

## Interface
- Parameters: none; the data width is fixed at 32.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `div_start_i` in 1: a divide instruction is in EX. It is held stable while this block stalls EX.
- `signed_div_i` in 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `annul_i` in 1: flush. Aborts any operation in progress.
- `result_o` out 64: `{remainder[63:32], quotient[31:0]}`. Valid only while `ready_o` is 1, and 0 otherwise.
- `ready_o` out 1: result valid this cycle.
- `stallreq_for_ex` out 1: stall request to the controller.

## Operation
- States: FREE, BY_ZERO, ON, END. Reset state is FREE. Reset values: `result_o`=0, `ready_o`=0, `stallreq_for_ex`=0. All internal registers (counter, partial remainder, quotient) reset to 0.
- `stallreq_for_ex` = `div_start_i & ~ready_o & ~annul_i`. It is combinational, so a request is raised in the same cycle the instruction enters EX.
- FREE:
  - `div_start_i`=1, `annul_i`=0, divisor≠0: latch the magnitudes of the operands, set count=0, record the quotient sign and remainder sign, go to ON.
  - divisor=0: go to BY_ZERO.
  - Otherwise stay in FREE.
- BY_ZERO: go to END with result forced to 0.
- ON: perform one restoring step per cycle.
  - Shift `{rem, dividend}` left by 1.
  - Trial-subtract the divisor, using a 33-bit subtraction.
  - If the difference is ≥0, keep it and shift in quotient bit 1. Otherwise shift in 0.
  - Increment count. After the 32nd step (count reaches 32), apply the sign fixup and go to END.
- Sign fixup (signed only):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Arithmetic is two's complement mod 2^32. So 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap.
- END: `ready_o`=1 and `result_o` is driven for exactly one cycle. The controller releases EX that cycle and the instruction advances. The next state is always FREE. A new `div_start_i` seen in FREE is a new instruction.
- `annul_i`=1 in any state: the next state is FREE and `ready_o`/`result_o` are 0 that cycle. No result is produced.
- `div_start_i` dropping in BY_ZERO or ON is treated as an abort, and the next state is FREE.
- Reset asserted mid-operation returns to FREE immediately, because reset is asynchronous.

## Timing
- Nonzero divisor, FREE at cycle 0:
  - Cycle 0: FREE captures the operands.
  - Cycles 1–32: ON.
  - Cycle 33: END, `ready_o`=1.
  - `stallreq_for_ex` is high for cycles 0–32 (33 cycles) and low at cycle 33.
  - Cycle 34: FREE.
- Zero divisor:
  - Cycle 0: FREE.
  - Cycle 1: BY_ZERO.
  - Cycle 2: END with result 0.
  - Stall is high for cycles 0–1.
- Back-to-back divides: if the second start arrives at cycle 34, the second result appears at cycle 67. There are no dead cycles beyond END→FREE.
- `annul_i` takes effect combinationally on `stallreq_for_ex` and on the next edge for the state.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_div_i` is honoured. Operands are converted to magnitude in FREE and the sign fixup is applied on the ON→END transition.
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` is ignored and every operation is unsigned.
  - The negation logic is not built.
  - Latency and the state machine are unchanged.

## Test plan
- Reset, then idle: hold `rst` for 2 cycles with `div_start_i`=0. Required: state FREE, all outputs 0, no stall.
- DIVU 100 / 7, start held: `stallreq_for_ex` high for 33 cycles. At cycle 33, `ready_o`=1 with `result_o`=`{0x00000002, 0x0000000E}` for one cycle, then FREE.
- DIV 0xFFFFFFF9 (−7) / 2 with `DIV_SIGNED_EN`: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Same operands without the macro: quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 5 / 0: `ready_o` at cycle 2 with `result_o`=0, and stall high for cycles 0–1 only.
- `annul_i` pulsed at cycle 10 of a DIVU: stall drops in that cycle, the state is FREE at cycle 11, and `ready_o` never asserts.
- Asynchronous `rst` mid-ON: `ready_o`/`stallreq_for_ex` clear without waiting for an edge. A subsequent 0xFFFFFFFF / 0x10 DIVU returns `{0xF, 0x0FFFFFFF}` at cycle 33.

Source files
------------

// File: rtl/div_if.sv
// div_if: EX-stage divider request/result bundle between pipeline (master) and div_unit (slave).
interface div_if;
  logic        div_start_i;
  logic        signed_div_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_for_ex;
  modport master (output div_start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
                  input result_o, ready_o, stallreq_for_ex);
  modport slave  (input div_start_i, signed_div_i, annul_i, opdata1_i, opdata2_i,
                  output result_o, ready_o, stallreq_for_ex);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-cycle restoring divider raising an EX stall request; define DIV_SIGNED_EN to honour signed_div_i.
module div_unit (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [31:0] rem, quo, dvs;
  logic [63:0] result_r;
  logic ready_r;
  logic [32:0] diff;
  logic [31:0] a_mag, b_mag, q_next, r_next, q_fix, r_fix;
  // quo starts as the dividend magnitude and fills with quotient bits from the right
  assign diff = {rem, quo[31]} - {1'b0, dvs};
  assign r_next = diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
  assign q_next = {quo[30:0], ~diff[32]};
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = (bus.signed_div_i & bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign b_mag = (bus.signed_div_i & bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  assign q_fix = neg_q ? -q_next : q_next;
  assign r_fix = neg_r ? -r_next : r_next;
`else
  assign a_mag = bus.opdata1_i;
  assign b_mag = bus.opdata2_i;
  assign q_fix = q_next;
  assign r_fix = r_next;
`endif
  assign bus.ready_o = ready_r & ~bus.annul_i;
  assign bus.result_o = bus.ready_o ? result_r : 64'd0;
  assign bus.stallreq_for_ex = bus.div_start_i & ~bus.ready_o & ~bus.annul_i & ~rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result_r <= '0;
      ready_r <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      ready_r <= 1'b0;
      result_r <= '0;
      if (bus.annul_i) state <= FREE;
      else case (state)
        FREE: if (bus.div_start_i) begin
          if (bus.opdata2_i == 32'd0) state <= BY_ZERO;
          else begin
            state <= ON;
            cnt <= '0;
            rem <= '0;
            quo <= a_mag;
            dvs <= b_mag;
`ifdef DIV_SIGNED_EN
            neg_q <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_r <= bus.signed_div_i & bus.opdata1_i[31];
`endif
          end
        end
        BY_ZERO: if (!bus.div_start_i) state <= FREE;
        else begin
          state <= END;
          ready_r <= 1'b1;
        end
        ON: if (!bus.div_start_i) state <= FREE;
        else begin
          rem <= r_next;
          quo <= q_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= END;
            ready_r <= 1'b1;
            result_r <= {r_fix, q_fix};
          end
        end
        END: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of latency, results, stall window, annul and async reset for div_unit.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  div_if bus();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int exp_cyc, input logic [63:0] exp_res, input string name);
    int cyc = -1;
    int stalls = 0;
    logic [63:0] res = '0;
    bus.div_start_i = 1'b1;
    bus.signed_div_i = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    for (int c = 0; c < 45 && cyc < 0; c++) begin
      @(negedge clk);
      if (bus.stallreq_for_ex) stalls++;
      if (bus.ready_o) begin
        cyc = c;
        res = bus.result_o;
      end
      @(posedge clk); #1;
    end
    total++;
    if (cyc !== exp_cyc) begin bad++; $display("FAIL %s ready_cycle got=%0d exp=%0d", name, cyc, exp_cyc); end
    total++;
    if (res !== exp_res) begin bad++; $display("FAIL %s result got=%h exp=%h", name, res, exp_res); end
    total++;
    if (stalls !== exp_cyc) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_cyc); end
  endtask

  task automatic idle_check(input string name);
    bus.div_start_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL %s idle_ready got=%b exp=0", name, bus.ready_o); end
    total++;
    if (bus.result_o !== 64'd0) begin bad++; $display("FAIL %s idle_result got=%h exp=0", name, bus.result_o); end
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL %s idle_stall got=%b exp=0", name, bus.stallreq_for_ex); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
    total++;
    if (bus.result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stallreq_for_ex); end
    rst = 1'b0;
    idle_check("post_reset");
  endtask

  task automatic test_divu();
    do_div(32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, "divu_100_7");
    idle_check("divu_100_7");
  endtask

  task automatic test_signed();
`ifdef DIV_SIGNED_EN
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
    idle_check("div_m7_2");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 33, {32'h0, 32'h80000000}, "div_min_m1");
    idle_check("div_min_m1");
`else
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'h1, 32'h7FFFFFFC}, "div_m7_2_unsigned");
    idle_check("div_m7_2_unsigned");
`endif
  endtask

  task automatic test_by_zero();
    do_div(32'd5, 32'd0, 1'b0, 2, 64'd0, "div_by_zero");
    idle_check("div_by_zero");
  endtask

  task automatic test_back_to_back();
    do_div(32'd1000, 32'd10, 1'b0, 33, {32'h0, 32'd100}, "b2b_first");
    do_div(32'd1001, 32'd10, 1'b0, 33, {32'h1, 32'd100}, "b2b_second");
    idle_check("b2b");
  endtask

  task automatic test_annul();
    int readies = 0;
    bus.div_start_i = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    bus.annul_i = 1'b1;
    #1;
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL annul_stall got=%b exp=0", bus.stallreq_for_ex); end
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.div_start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o) readies++;
    end
    @(posedge clk); #1;
    total++;
    if (readies !== 0) begin bad++; $display("FAIL annul_no_ready got=%0d exp=0", readies); end
    do_div(32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, "after_annul");
    idle_check("after_annul");
  endtask

  task automatic test_async_rst();
    bus.div_start_i = 1'b1;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.stallreq_for_ex !== 1'b0) begin bad++; $display("FAIL async_rst_stall got=%b exp=0", bus.stallreq_for_ex); end
    total++;
    if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL async_rst_ready got=%b exp=0", bus.ready_o); end
    bus.div_start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_div(32'hFFFFFFFF, 32'h10, 1'b0, 33, {32'hF, 32'h0FFFFFFF}, "after_async_rst");
    idle_check("after_async_rst");
  endtask

  initial begin
    bus.div_start_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    test_reset();
    test_divu();
    test_signed();
    test_by_zero();
    test_back_to_back();
    test_annul();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
